// File: rtl/neuron_accum_act_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_accum_act_if
// Description : Term-in / activation-out stream bundle for the neuron stage.
//               master = upstream/downstream environment, slave = neuron.
// Revision    : 1.0  initial release
// ============================================================================
interface neuron_accum_act_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/neuron_accum_act.sv
`default_nettype none
// ============================================================================
// Module      : neuron_accum_act
// Description : Accumulates cfg_len partial-sum terms onto a bias, applies an
//               arithmetic right shift, then ReLU with positive saturation and
//               offers the activation on a valid/ready handshake.
//               Optional macro LEAKY_RELU_EN: negatives become s>>>3 (saturated
//               to the most negative DW value) instead of 0.
// Revision    : 1.0  initial release
// ============================================================================
module neuron_accum_act #(
    parameter int DW    = 16,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [CNT_W-1:0] cfg_len,
    input  wire logic [DW-1:0]    cfg_bias,
    input  wire logic [3:0]       cfg_shift,
    neuron_accum_act_if.slave     s_if,
    output logic                  busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Largest / smallest representable activation, sign-extended to ACC_W.
    localparam logic signed [ACC_W-1:0] c_pos_max = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
`ifdef LEAKY_RELU_EN
    localparam logic signed [ACC_W-1:0] c_neg_min = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         r_len;
    logic [3:0]               r_shift;
    logic                     r_out_valid;
    logic [DW-1:0]            r_out_data;

    logic                     w_in_ready;
    logic                     w_accept;
    logic signed [ACC_W-1:0]  w_term_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [DW-1:0]            w_act;

    assign w_in_ready = (r_state == ST_IDLE) || (r_state == ST_ACC);
    assign w_accept   = s_if.in_valid && w_in_ready;
    assign w_term_ext = {{(ACC_W-DW){s_if.in_data[DW-1]}}, s_if.in_data};
    assign w_bias_ext = {{(ACC_W-DW){cfg_bias[DW-1]}}, cfg_bias};
    assign w_shifted  = r_acc >>> r_shift;

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_data  = r_out_data;
    assign busy           = (r_state != ST_IDLE);

    // Activation of the requantised accumulator: clamp to the DW range.
    always_comb begin
        w_act = '0;
        if (w_shifted < 0) begin
`ifdef LEAKY_RELU_EN
            if ((w_shifted >>> 3) < c_neg_min) begin
                w_act = c_neg_min[DW-1:0];
            end else begin
                w_act = w_shifted[DW+2:3];
            end
`else
            w_act = '0;
`endif
        end else if (w_shifted > c_pos_max) begin
            w_act = c_pos_max[DW-1:0];
        end else begin
            w_act = w_shifted[DW-1:0];
        end
    end

    // Control FSM with accumulator, term counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_shift     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Configuration is captured only here, so later edits
                        // cannot disturb an activation in progress.
                        r_len   <= cfg_len;
                        r_shift <= cfg_shift;
                        r_acc   <= w_bias_ext + w_term_ext;
                        r_count <= CNT_W'(1);
                        r_state <= (cfg_len <= CNT_W'(1)) ? ST_ACT : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc   <= r_acc + w_term_ext;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count + CNT_W'(1) == r_len) begin
                            r_state <= ST_ACT;
                        end
                    end
                end
                ST_ACT: begin
                    r_out_data  <= w_act;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (s_if.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_neuron_accum_act.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_accum_act
// Description : Directed self-checking bench for neuron_accum_act
//               (DW=16, ACC_W=32, CNT_W=8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_accum_act;
    localparam int DW    = 16;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] cfg_len   = '0;
    logic [DW-1:0]    cfg_bias  = '0;
    logic [3:0]       cfg_shift = '0;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    neuron_accum_act_if #(.DW(DW)) u_if ();

    neuron_accum_act #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .s_if      (u_if.slave),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n terms back-to-back, then check ACT-cycle latency, result and
    // the handshake with out_ready held high. With scramble set, cfg_* is
    // changed after the first term and must be ignored by the run.
    task automatic run(input string tag, input int len, input int bias, input int shift,
                       input int t0, input int t1, input int t2, input int n,
                       input logic [15:0] exp, input bit scramble);
        int terms[3];
        terms[0] = t0;
        terms[1] = t1;
        terms[2] = t2;
        cfg_len        = CNT_W'(len);
        cfg_bias       = DW'(bias);
        cfg_shift      = 4'(shift);
        u_if.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = DW'(terms[i]);
            tick();
            if (scramble && i == 0) begin
                cfg_len   = 8'd7;
                cfg_bias  = 16'd1000;
                cfg_shift = 4'd5;
            end
        end
        u_if.in_valid = 1'b0;
        check({tag, "_act_novalid"}, 32'(u_if.out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(u_if.out_valid), 32'd1);
        check({tag, "_data"},  32'(u_if.out_data),  32'(exp));
        tick();
        check({tag, "_done"},  32'(u_if.out_valid), 32'd0);
        check({tag, "_idle"},  32'(busy),           32'd0);
        check({tag, "_hold"},  32'(u_if.out_data),  32'(exp));
    endtask

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.out_ready = 1'b0;

        // Reset held for two edges.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_out_data",  32'(u_if.out_data),  32'd0);
        check("rst_busy",      32'(busy),           32'd0);
        check("rst_in_ready",  32'(u_if.in_ready),  32'd1);

        // 10+5+6+7 = 28
        run("sum3", 3, 10, 0, 5, 6, 7, 3, 16'd28, 1'b0);
        // -100+20 = -80, negative path
`ifdef LEAKY_RELU_EN
        run("neg", 2, 0, 0, -100, 20, 0, 2, 16'hFFF6, 1'b0);  // -80>>>3 = -10
`else
        run("neg", 2, 0, 0, -100, 20, 0, 2, 16'd0, 1'b0);
`endif
        // 32767+32767 = 65534: saturates unshifted, 16383 after >>>2
        run("sat", 2, 0, 0, 32767, 32767, 0, 2, 16'd32767, 1'b0);
        run("sat_sh2", 2, 0, 2, 32767, 32767, 0, 2, 16'd16383, 1'b0);
        // len=0 behaves as one term: 3+4 = 7
        run("len0", 0, 3, 0, 4, 0, 0, 1, 16'd7, 1'b0);
        // cfg edits after the first accept ignored: 1+2+3 = 6
        run("cfg_lock", 2, 1, 0, 2, 3, 0, 2, 16'd3 + 16'd2 + 16'd1, 1'b1);
        // -4096 >>> 4 = -256 negative; 4096>>>4 = 256 positive
`ifdef LEAKY_RELU_EN
        run("neg_sh", 1, 0, 4, -4096, 0, 0, 1, 16'hFFE0, 1'b0);
`else
        run("neg_sh", 1, 0, 4, -4096, 0, 0, 1, 16'd0, 1'b0);
`endif
        run("pos_sh", 1, 0, 4, 4096, 0, 0, 1, 16'd256, 1'b0);

        // Backpressure in OUT: result held, offered terms refused.
        cfg_len        = 8'd1;
        cfg_bias       = 16'd0;
        cfg_shift      = 4'd0;
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_data   = 16'd123;
        tick();
        u_if.in_data   = 16'd1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(u_if.out_valid), 32'd1);
            check("bp_data",     32'(u_if.out_data),  32'd123);
            check("bp_in_ready", 32'(u_if.in_ready),  32'd0);
            tick();
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        tick();
        check("bp_release", 32'(u_if.out_valid), 32'd0);
        // The refused 1000 must not leak into the next result.
        run("bp_next", 1, 0, 0, 1, 0, 0, 1, 16'd1, 1'b0);

        // Reset mid-accumulation, then a clean single-term run: -4+9 = 5
        cfg_len       = 8'd3;
        cfg_bias      = 16'd50;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 16'd50;
        tick();
        u_if.in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_idle",     32'(busy),           32'd0);
        check("abort_in_ready", 32'(u_if.in_ready),  32'd1);
        check("abort_out_data", 32'(u_if.out_data),  32'd0);
        run("after_abort", 1, -4, 0, 9, 0, 0, 1, 16'd5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit exceeded");
    end
endmodule
`default_nettype wire
